// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, one bit per clock,
// with repeat count, inter-repetition gap cycles, abort and busy/done status.
module seq_pattern_tx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int REP_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    output logic               x,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] shift_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [REP_W-1:0]   rep_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               x_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    logic [LEN_W-1:0]   len_d;
    logic [MAX_LEN-1:0] pat_d;
    logic [REP_W-1:0]   rep_d;

    // The pattern is left-aligned at capture so the first bit is always the MSB;
    // every bit then comes from a fixed position and no variable indexing is needed.
    always_comb begin
        len_d = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
        pat_d = pattern << (LEN_W'(MAX_LEN) - len_d);
        rep_d = (reps == '0) ? REP_W'(1) : reps;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        pat_q <= pat_d;
                        len_q <= len_d;
                        rep_q <= rep_d;
                        gap_q <= gap;
                        if (len_d != '0) begin
                            state_q <= SEND;
                            x_q     <= pat_d[MAX_LEN-1];
                            shift_q <= pat_d << 1;
                            cnt_q   <= len_d - LEN_W'(1);
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (abort) begin
                        state_q <= IDLE;
                        x_q     <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        x_q     <= shift_q[MAX_LEN-1];
                        shift_q <= shift_q << 1;
                        cnt_q   <= cnt_q - LEN_W'(1);
                    end else if (rep_q > REP_W'(1)) begin
                        rep_q <= rep_q - REP_W'(1);
                        if (gap_q != '0) begin
                            state_q   <= GAP;
                            gap_cnt_q <= gap_q;
                            x_q       <= 1'b0;
                            valid_q   <= 1'b0;
                        end else begin
                            x_q     <= pat_q[MAX_LEN-1];
                            shift_q <= pat_q << 1;
                            cnt_q   <= len_q - LEN_W'(1);
                        end
                    end else begin
                        state_q <= DONE;
                        x_q     <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_cnt_q == GAP_W'(1)) begin
                        state_q <= SEND;
                        x_q     <= pat_q[MAX_LEN-1];
                        shift_q <= pat_q << 1;
                        cnt_q   <= len_q - LEN_W'(1);
                        valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                DONE: begin
                    // done drops through its default; start is not looked at here
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random jobs compared cycle by cycle against
// an expected-output list built from the job parameters.
module tb_seq_pattern_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic [3:0]  reps = '0;
    logic [3:0]  gap = '0;
    logic        x, valid, busy, done;

    int checks = 0;
    int errors = 0;

    // expected {x,valid,busy,done} for each cycle after the start edge
    logic [3:0] exp_q[$];

    seq_pattern_tx dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .reps(reps), .gap(gap),
        .x(x), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc, input logic [3:0] expv);
        logic [3:0] obs;
        obs = {x, valid, busy, done};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc %0d: xvbd got %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic build_model(input logic [15:0] p, input int l, input int r, input int g);
        logic [15:0] t;
        int L, R;
        exp_q.delete();
        L = (l > 16) ? 16 : l;
        R = (r == 0) ? 1 : r;
        if (L > 0) begin
            for (int rep = 0; rep < R; rep++) begin
                for (int b = L - 1; b >= 0; b--) begin
                    t = p >> b;
                    exp_q.push_back({t[0], 3'b110});
                end
                if (rep < R - 1)
                    for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0001);
    endtask

    // Called at a falling edge; issues start, then checks every cycle of the job plus
    // two idle cycles while scrambling the job inputs to prove they are not re-read.
    task automatic run_job(input string tag, input logic [15:0] p, input int l, input int r,
                           input int g, input int abort_at, input int extra_start_at);
        int n;
        bit aborted;
        logic [3:0] expv;
        build_model(p, l, r, g);
        n = exp_q.size();
        aborted = 0;
        pattern = p; len = 5'(l); reps = 4'(r); gap = 4'(g);
        start = 1'b1; abort = 1'b0;
        for (int cyc = 1; cyc <= n + 2; cyc++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            expv = (aborted || cyc > n) ? 4'b0000 : exp_q[cyc-1];
            check(tag, cyc, expv);
            pattern = 16'($urandom); len = 5'($urandom); reps = 4'($urandom); gap = 4'($urandom);
            if (cyc == abort_at) begin
                abort = 1'b1;
                aborted = 1;
            end
            if (cyc == extra_start_at && cyc <= n) start = 1'b1;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        int l, r, g, ab;
        logic [15:0] p;

        #1 rst = 1'b1;
        #2 check("reset_async", 0, 4'b0000);
        repeat (2) @(negedge clk);
        check("reset_hold", 0, 4'b0000);
        rst = 1'b0;

        run_job("s1_b2_len8", 16'h00B2, 8, 1, 0, 0, 0);
        run_job("s2_gap2", 16'h0005, 3, 2, 2, 0, 0);
        run_job("s3_b2b_xstart", 16'h0002, 2, 3, 0, 0, 3);
        run_job("s4_abort", 16'h00B2, 8, 1, 0, 3, 0);

        // simultaneous start and abort in IDLE must not launch anything
        pattern = 16'h00B2; len = 5'd8; reps = 4'd1; gap = 4'd0;
        start = 1'b1; abort = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            check("start_abort_idle", cyc, 4'b0000);
        end

        run_job("len0", 16'hFFFF, 0, 3, 2, 0, 0);
        run_job("len20_clamp", 16'h8001, 20, 1, 0, 0, 0);
        run_job("reps0", 16'h00B2, 8, 0, 3, 0, 0);
        run_job("abort_in_gap", 16'h000D, 4, 3, 3, 5, 0);

        // asynchronous reset between edges in the middle of SEND
        pattern = 16'h00B2; len = 5'd8; reps = 4'd2; gap = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_send", 1, 4'b1110);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_send", 0, 4'b0000);
        @(negedge clk);
        check("rst_held", 0, 4'b0000);
        rst = 1'b0;
        run_job("after_rst", 16'h00B2, 8, 1, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            p  = 16'($urandom);
            l  = $urandom_range(0, 20);
            r  = $urandom_range(0, 3);
            g  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            run_job($sformatf("rand%0d", i), p, l, r, g, ab, (ab == 0) ? $urandom_range(1, 6) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It drives the single-bit stimulus stream that feeds the team's serial sequence detector: one bit per clock, MSB-first. A programmable pattern word is captured on a start request and shifted out. The block supports a repeat count, idle gap cycles between repetitions, and abort, and it reports busy/done status to the controlling logic or bench.

Parameters:
MAX_LEN, 16, width of pattern input; maximum bits per repetition
LEN_W, 5, width of len input (must hold MAX_LEN)
REP_W, 4, width of reps input
GAP_W, 4, width of gap input

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  transmit request, sampled on rising edge in IDLE only
abort  input  1  cancel transmission, sampled on rising edge
pattern  input  MAX_LEN  bits to send; bit len-1 is sent first, bit 0 last
len  input  LEN_W  bits per repetition; 0 = empty job; values >MAX_LEN clamp to MAX_LEN
reps  input  REP_W  number of repetitions; 0 is treated as 1
gap  input  GAP_W  idle cycles inserted between consecutive repetitions
x  output  1  serial data bit (to detector input)
valid  output  1  high when x carries a pattern bit
busy  output  1  high while a job is in progress
done  output  1  one-cycle pulse when a job completes normally

Behaviour:
- All outputs are registered. Reset (async, immediate) forces x=0, valid=0, busy=0, done=0, state=IDLE, and clears all counters.
- States: IDLE, SEND, GAP, DONE.
- IDLE: x=0, valid=0, busy=0. On an edge with start=1 and abort=0, the block captures pattern, len (clamped), reps (0→1) and gap.
  - If len≠0: go to SEND, bit index = len-1. The first bit appears on x after that same edge, so start-to-first-bit latency is 1 cycle.
  - If len=0: go to DONE directly. valid never asserts.
- SEND: x = captured pattern[bit index], valid=1, busy=1. Each bit is held exactly one cycle, and the index decrements each edge.
  - After bit 0 with repetitions remaining and gap>0: go to GAP.
  - After bit 0 with repetitions remaining and gap=0: restart at index len-1 with no bubble (back-to-back).
  - After bit 0 of the last repetition: go to DONE.
- GAP: x=0, valid=0, busy=1 for exactly gap cycles, then SEND at index len-1.
- DONE: exactly one cycle with done=1, busy=0, valid=0, x=0, then IDLE. start is ignored in DONE.
- start in SEND, GAP or DONE is ignored. It is not queued.
- Inputs pattern, len, reps and gap are ignored after capture; changing them mid-job has no effect.
- abort=1 on any edge in SEND, GAP or DONE: next state IDLE, all outputs 0, done is not pulsed.
- abort=1 in IDLE has no effect. With simultaneous start+abort in IDLE, abort wins and no job starts.
- Total job duration with len=L, reps=R, gap=G: R·L + (R−1)·G cycles of busy, then 1 done cycle.
- Counters must not wrap: the repetition counter saturates at its final value, and the gap counter is reloaded per repetition.
- Reset mid-operation: immediate return to IDLE outputs. After reset deassertion, the next start behaves as a fresh job.

Test Plan:
- Reset, then start with pattern=16'h00B2, len=8, reps=1, gap=0 → x on cycles 1..8 = 1,0,1,1,0,0,1,0 with valid=1 and busy=1; done=1 on cycle 9 only; idle x=0 afterwards.
- pattern=16'h0005, len=3, reps=2, gap=2 → cycles 1..8 show x=1,0,1 (valid=1), 0,0 (valid=0, busy=1), 1,0,1 (valid=1); done on cycle 9.
- pattern=16'h0002, len=2, reps=3, gap=0 → x=1,0,1,0,1,0 back-to-back on cycles 1..6 with valid constantly 1; done on cycle 7. A second start pulsed on cycle 3 is ignored (no extra bits).
- Job as in scenario 1 with abort=1 at the edge ending cycle 3 → from cycle 4, x=0, valid=0, busy=0; no done pulse ever. Next, start+abort together in IDLE → no job.
- start with len=0 → done on cycle 1, valid never high. start with len=20, pattern=16'h8001, reps=1 → 16 bits 1,0×14,1; done on cycle 17. start with reps=0 → behaves as reps=1.
- rst asserted asynchronously mid-SEND (between clock edges) → x, valid, busy and done go to 0 without waiting for an edge. After release, the scenario-1 job runs correctly from start.
